tx_resp_sched: RTL

- Scheduler between the two response sources of the system controller path and the single TX FIFO write port.
- Source one is a register-file read result (1 byte). Source two is an ALU result (2 bytes, LSB first).
- Each source has its own one-entry holding slot, so sources are decoupled from FIFO backpressure.
- Slots are arbitrated round-robin and drained byte by byte into the FIFO, honouring FIFO_FULL.

---
 rtl/tx_resp_sched_pkg.sv | 19 +
 rtl/tx_resp_sched_slot.sv | 36 +++
 rtl/tx_resp_sched.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tx_resp_sched_pkg.sv
// Shared types for the TX response scheduler.
// State encodings, source IDs and default byte width.
package tx_resp_sched_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SEND_RD  = 2'b01,
        SEND_LSB = 2'b10,
        SEND_MSB = 2'b11
    } state_e;

    typedef enum logic {
        SRC_RD  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

endpackage

// File: rtl/tx_resp_sched_slot.sv
// One-entry holding register with VLD/RDY capture.
// Freed by an external strobe once its contents are fully sent.
module resp_slot #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         VLD,
    input  logic [W-1:0] DATA,
    output logic         RDY,
    input  logic         FREE,
    output logic         FULL,
    output logic [W-1:0] Q
);

    logic         full_q;
    logic [W-1:0] data_q;

    // Free and capture never coincide: capture needs an empty slot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (FREE) begin
            full_q <= 1'b0;
        end else if (VLD && !full_q) begin
            full_q <= 1'b1;
            data_q <= DATA;
        end
    end

    assign RDY  = !full_q;
    assign FULL = full_q;
    assign Q    = data_q;

endmodule

// File: rtl/tx_resp_sched.sv
// Round-robin scheduler from RD and ALU response slots
// into the TX FIFO write port, byte by byte.
import tx_resp_sched_pkg::*;

module tx_resp_sched #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ALU_W  = 2 * DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RD_VLD,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              RD_RDY,
    input  logic              ALU_VLD,
    input  logic [ALU_W-1:0]  ALU_OUT,
    output logic              ALU_RDY,
    input  logic              FIFO_FULL,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD,
    output logic              BUSY,
    output logic [7:0]        TX_CNT
);

    state_e              state_q, state_d;
    src_e                last_q, last_d;
    logic [7:0]          cnt_q;
    logic                rd_full, alu_full;
    logic                free_rd, free_alu;
    logic [DATA_W-1:0]   rd_q;
    logic [ALU_W-1:0]    alu_q;
    logic                tx_vld;
    logic [DATA_W-1:0]   tx_data;

    resp_slot #(.W(DATA_W)) u_rd_slot (
        .CLK  (CLK),
        .RST  (RST),
        .VLD  (RD_VLD),
        .DATA (RD_DATA),
        .RDY  (RD_RDY),
        .FREE (free_rd),
        .FULL (rd_full),
        .Q    (rd_q)
    );

    resp_slot #(.W(ALU_W)) u_alu_slot (
        .CLK  (CLK),
        .RST  (RST),
        .VLD  (ALU_VLD),
        .DATA (ALU_OUT),
        .RDY  (ALU_RDY),
        .FREE (free_alu),
        .FULL (alu_full),
        .Q    (alu_q)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            last_q  <= SRC_ALU;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (tx_vld) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        tx_vld   = 1'b0;
        tx_data  = '0;
        free_rd  = 1'b0;
        free_alu = 1'b0;
        case (state_q)
            IDLE: begin
                // LAST only moves when both slots contend.
                if (rd_full && alu_full) begin
                    if (last_q == SRC_ALU) begin
                        state_d = SEND_RD;
                        last_d  = SRC_RD;
                    end else begin
                        state_d = SEND_LSB;
                        last_d  = SRC_ALU;
                    end
                end else if (rd_full) begin
                    state_d = SEND_RD;
                end else if (alu_full) begin
                    state_d = SEND_LSB;
                end
            end
            SEND_RD: begin
                if (!FIFO_FULL) begin
                    tx_vld  = 1'b1;
                    tx_data = rd_q;
                    free_rd = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND_LSB: begin
                if (!FIFO_FULL) begin
                    tx_vld  = 1'b1;
                    tx_data = alu_q[DATA_W-1:0];
                    state_d = SEND_MSB;
                end
            end
            SEND_MSB: begin
                if (!FIFO_FULL) begin
                    tx_vld   = 1'b1;
                    tx_data  = alu_q[ALU_W-1:DATA_W];
                    free_alu = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign TX_D_VLD  = tx_vld;
    assign TX_P_DATA = tx_data;
    assign TX_CNT    = cnt_q;
    assign BUSY      = rd_full || alu_full || (state_q != IDLE);

endmodule
